// File: rtl/ddfs_dac_spi_serializer_pkg.sv
// ddfs_defines: DAC frame constants, sequencer state encoding and offset-binary conversion
// shared by the DDFS-to-DAC SPI serializer and its shifter.
package ddfs_defines;
   localparam logic [7:0] DAC_CMD_A = 8'h00;
   localparam logic [7:0] DAC_CMD_B = 8'h21;
   localparam int         FRAME_LEN = 24;
   typedef enum logic [2:0] {ST_IDLE, ST_SHIFT_A, ST_GAP_A, ST_SHIFT_B, ST_GAP_B} state_e;
   function automatic logic [15:0] to_offset(input logic [15:0] w);
      return {~w[15], w[14:0]};
   endfunction
endpackage

// File: rtl/ddfs_dac_spi_serializer_shifter.sv
// dac_spi_shifter: shifts one 24-bit word MSB first on an idle-high divided SCLK,
// holding SYNC_n low for exactly 2*FRAME_LEN*CLK_DIV clocks.
module dac_spi_shifter
   import ddfs_defines::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic [FRAME_LEN-1:0] word,
   output logic                 sclk,
   output logic                 sync_n,
   output logic                 din,
   output logic                 done
);
   localparam int DW = $clog2(CLK_DIV);
   localparam int HW = $clog2(2 * FRAME_LEN);
   logic                 active_q, active_d;
   logic                 sclk_q, sclk_d;
   logic                 sync_n_q, sync_n_d;
   logic                 din_q, din_d;
   logic [DW-1:0]        div_q, div_d;
   logic [HW-1:0]        half_q, half_d;
   logic [FRAME_LEN-1:0] sr_q, sr_d;
   logic                 tick;
   assign tick   = active_q && div_q == DW'(CLK_DIV - 1);
   // The last half-period is the low phase after the 24th falling edge.
   assign done   = tick && half_q == HW'(2 * FRAME_LEN - 1);
   assign sclk   = sclk_q;
   assign sync_n = sync_n_q;
   assign din    = din_q;
   always_comb begin
      active_d = active_q;
      sclk_d   = sclk_q;
      sync_n_d = sync_n_q;
      din_d    = din_q;
      div_d    = div_q;
      half_d   = half_q;
      sr_d     = sr_q;
      if (load) begin
         active_d = 1'b1;
         sclk_d   = 1'b1;
         sync_n_d = 1'b0;
         din_d    = word[FRAME_LEN-1];
         div_d    = '0;
         half_d   = '0;
         sr_d     = {word[FRAME_LEN-2:0], 1'b0};
      end else if (done) begin
         active_d = 1'b0;
         sclk_d   = 1'b1;
         sync_n_d = 1'b1;
         din_d    = 1'b0;
      end else if (active_q) begin
         div_d = tick ? '0 : div_q + 1'b1;
         if (tick) begin
            half_d = half_q + 1'b1;
            sclk_d = ~sclk_q;
            if (!sclk_q) begin
               din_d = sr_q[FRAME_LEN-1];
               sr_d  = {sr_q[FRAME_LEN-2:0], 1'b0};
            end
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q <= 1'b0;
         sclk_q   <= 1'b1;
         sync_n_q <= 1'b1;
         din_q    <= 1'b0;
         div_q    <= '0;
         half_q   <= '0;
         sr_q     <= '0;
      end else begin
         active_q <= active_d;
         sclk_q   <= sclk_d;
         sync_n_q <= sync_n_d;
         din_q    <= din_d;
         div_q    <= div_d;
         half_q   <= half_d;
         sr_q     <= sr_d;
      end
   end
endmodule

// File: rtl/ddfs_dac_spi_serializer.sv
// ddfs_dac_spi_serializer: captures a DDFS cosine/sine pair on strobe and sends them as
// offset-binary frames A (cosine) and B (sine) to a dual 16-bit SPI DAC.
module ddfs_dac_spi_serializer
   import ddfs_defines::*;
#(
   parameter int SAN_CP  = 16,
   parameter int CLK_DIV = 4,
   parameter int GAP_CYC = 4
) (
   input  logic              clock_100_MHz,
   input  logic              clear_DAC_n,
   input  logic [SAN_CP-1:0] COSINE_WAVE,
   input  logic [SAN_CP-1:0] SINE_WAVE,
   input  logic              SAMPLE_STROBE,
   output logic              DAC_SCLK,
   output logic              DAC_SYNC_n,
   output logic              DAC_DIN,
   output logic              BUSY,
   output logic              FRAME_DONE,
   output logic [7:0]        DROP_COUNT
);
   localparam int GW = $clog2(GAP_CYC + 1);
   state_e               state_q, state_d;
   logic [15:0]          sin_q, sin_d;
   logic [GW-1:0]        gap_q, gap_d;
   logic [7:0]           drop_q, drop_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 gap_end, load, sh_done;
   logic [FRAME_LEN-1:0] load_word;
   assign gap_end = gap_q == GW'(GAP_CYC - 1);
   // Frame A is loaded straight from the inputs on the accepting edge; only sine waits in a register.
   assign load      = (state_q == ST_IDLE && SAMPLE_STROBE) || (state_q == ST_GAP_A && gap_end);
   assign load_word = state_q == ST_IDLE ? {DAC_CMD_A, to_offset(COSINE_WAVE)} : {DAC_CMD_B, sin_q};
   assign BUSY       = busy_q;
   assign FRAME_DONE = done_q;
   assign DROP_COUNT = drop_q;
   dac_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
      .clk    (clock_100_MHz),
      .rst_n  (clear_DAC_n),
      .load   (load),
      .word   (load_word),
      .sclk   (DAC_SCLK),
      .sync_n (DAC_SYNC_n),
      .din    (DAC_DIN),
      .done   (sh_done)
   );
   always_comb begin
      state_d = state_q;
      sin_d   = sin_q;
      gap_d   = gap_q;
      drop_d  = (SAMPLE_STROBE && state_q != ST_IDLE && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
      done_d  = state_q == ST_GAP_B && gap_end;
      case (state_q)
         ST_IDLE: if (SAMPLE_STROBE) begin
            state_d = ST_SHIFT_A;
            sin_d   = to_offset(SINE_WAVE);
         end
         ST_SHIFT_A: if (sh_done) begin
            state_d = ST_GAP_A;
            gap_d   = '0;
         end
         ST_GAP_A: begin
            gap_d   = gap_q + 1'b1;
            state_d = gap_end ? ST_SHIFT_B : ST_GAP_A;
         end
         ST_SHIFT_B: if (sh_done) begin
            state_d = ST_GAP_B;
            gap_d   = '0;
         end
         ST_GAP_B: begin
            gap_d   = gap_q + 1'b1;
            state_d = gap_end ? ST_IDLE : ST_GAP_B;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = state_d != ST_IDLE;
   end
   always_ff @(posedge clock_100_MHz or negedge clear_DAC_n) begin
      if (!clear_DAC_n) begin
         state_q <= ST_IDLE;
         sin_q   <= '0;
         gap_q   <= '0;
         drop_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sin_q   <= sin_d;
         gap_q   <= gap_d;
         drop_q  <= drop_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end
endmodule
